// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite channel bundle (32-bit address/data) between a register slave and its master.
interface axi_lite_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  addr_t              awaddr;
  logic               awvalid;
  logic               awready;
  data_t              wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wvalid;
  logic               wready;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;
  addr_t              araddr;
  logic               arvalid;
  logic               arready;
  data_t              rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite bank of NUM_REGS 32-bit registers with one-entry AW/W buffers and per-register write strobes.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs #(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_if.slave              s_axi_lite,
  output logic [NUM_REGS*32-1:0] regs_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BYTE_W = 8;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0]  RESP_ERR  = 2'b10;
`else
  localparam logic [1:0]  RESP_ERR  = 2'b00;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic              wr_ok, rd_ok;
  logic [ADDR_W-1:0] wr_word, rd_word;
  logic [DATA_W-1:0] rd_sel;

  assign aw_hs   = s_axi_lite.awvalid && !aw_full_q;
  assign w_hs    = s_axi_lite.wvalid  && !w_full_q;
  assign ar_hs   = s_axi_lite.arvalid && !rvalid_q;
  // A write may only commit once the previous response has fully retired.
  assign commit  = aw_full_q && w_full_q && !bvalid_q;
  assign wr_ok   = in_range(awaddr_q);
  assign wr_word = word_idx(awaddr_q);
  assign rd_ok   = in_range(s_axi_lite.araddr);
  assign rd_word = word_idx(s_axi_lite.araddr);

  // Read mux samples the pre-commit register value.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_word == i) rd_sel = regs_q[i];
    end
  end

  always_comb begin
    regs_d     = regs_q;
    aw_full_d  = aw_full_q;
    awaddr_d   = awaddr_q;
    w_full_d   = w_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi_lite.awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi_lite.wdata;
      wstrb_d  = s_axi_lite.wstrb;
    end
    if (bvalid_q && s_axi_lite.bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_ERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && (wr_word == i)) begin
          for (int unsigned k = 0; k < STRB_W; k++) begin
            if (wstrb_q[k]) regs_d[i][BYTE_W*k +: BYTE_W] = wdata_q[BYTE_W*k +: BYTE_W];
          end
          wr_pulse_d[i] = 1'b1;
        end
      end
    end

    if (rvalid_q && s_axi_lite.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_sel : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[DATA_W*i +: DATA_W] = regs_q[i];
    end
  end

  assign wr_pulse           = wr_pulse_q;
  assign s_axi_lite.awready = !aw_full_q;
  assign s_axi_lite.wready  = !w_full_q;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.arready = !rvalid_q;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = rresp_q;
endmodule
